// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read-back BIST sequencer for a single-port RAM.
// Fills the array with a selectable pattern, reads every word back through a
// one-deep expected-data pipeline and reports busy/done/pass/first fail address.
// Steps only on tick, so all RAM-side outputs hold for a whole tick period.
// Optional: define RAM_BIST_ERRCNT_EN to add the err_cnt total-mismatch output.
module ram_bist_ctrl #(
   parameter int         AW   = 7,
   parameter int         DW   = 8,
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          start,
   input  logic [1:0]    pattern,
   output logic [AW-1:0] ram_a,
   output logic [DW-1:0] ram_d,
   output logic          ram_we,
   input  logic [DW-1:0] ram_q,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW-1:0] fail_addr
`ifdef RAM_BIST_ERRCNT_EN
   ,
   output logic [AW:0]   err_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_reg;
   logic [AW-1:0] addr_reg;
   logic [1:0]    pat_reg;
   logic [7:0]    lfsr_reg;
   logic [DW-1:0] exp_reg;
   logic [AW-1:0] exp_addr_reg;
   logic          pipe_valid_reg;
   logic          err_reg;
`ifdef RAM_BIST_ERRCNT_EN
   logic [AW:0]   err_cnt_reg;
`endif

   // 8-bit Fibonacci LFSR step used by pattern 3
   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // Pattern word for address n; l is the LFSR value belonging to that address
   function automatic logic [DW-1:0] pat_word(input logic [1:0]    p,
                                              input logic [AW-1:0] n,
                                              input logic [7:0]    l);
      logic [DW-1:0] w;
      case (p)
         2'd0:    w = DW'(n);
         2'd1:    w = n[0] ? DW'(8'hAA) : DW'(8'h55);
         2'd2:    w = ~DW'(n);
         default: w = DW'(l);
      endcase
      return w;
   endfunction

   logic [AW-1:0] addr_inc;
   logic [7:0]    lfsr_adv;
   logic          at_max;
   logic [DW-1:0] cur_word;
   logic [DW-1:0] next_word;
   logic          mismatch;

   assign addr_inc  = addr_reg + AW'(1);
   assign lfsr_adv  = lfsr_step(lfsr_reg);
   assign at_max    = (addr_reg == {AW{1'b1}});
   assign cur_word  = pat_word(pat_reg, addr_reg, lfsr_reg);
   assign next_word = pat_word(pat_reg, addr_inc, lfsr_adv);
   // A compare happens only on a stepping tick of the read/drain phases with a valid expectation
   assign mismatch  = tick && pipe_valid_reg && (ram_q != exp_reg) &&
                      ((state_reg == S_READ) || (state_reg == S_DRAIN));

   // Sequencer FSM with registered RAM-side and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         addr_reg       <= '0;
         pat_reg        <= '0;
         lfsr_reg       <= SEED;
         exp_reg        <= '0;
         exp_addr_reg   <= '0;
         pipe_valid_reg <= 1'b0;
         err_reg        <= 1'b0;
         ram_a          <= '0;
         ram_d          <= '0;
         ram_we         <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_addr      <= '0;
`ifdef RAM_BIST_ERRCNT_EN
         err_cnt_reg    <= '0;
`endif
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               // start wins over a coincident tick; the first write step waits for the next tick
               if (start) begin
                  state_reg      <= S_WRITE;
                  addr_reg       <= '0;
                  lfsr_reg       <= SEED;
                  pat_reg        <= pattern;
                  pipe_valid_reg <= 1'b0;
                  err_reg        <= 1'b0;
                  ram_a          <= '0;
                  ram_d          <= pat_word(pattern, '0, SEED);
                  ram_we         <= 1'b1;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  fail_addr      <= '0;
`ifdef RAM_BIST_ERRCNT_EN
                  err_cnt_reg    <= '0;
`endif
               end
            end
            S_WRITE: begin
               if (tick) begin
                  if (at_max) begin
                     state_reg <= S_READ;
                     addr_reg  <= '0;
                     lfsr_reg  <= SEED;
                     ram_a     <= '0;
                     ram_d     <= '0;
                     ram_we    <= 1'b0;
                  end else begin
                     addr_reg  <= addr_inc;
                     lfsr_reg  <= lfsr_adv;
                     ram_a     <= addr_inc;
                     ram_d     <= next_word;
                  end
               end
            end
            S_READ: begin
               if (tick) begin
                  // The word read at this address returns on the next tick
                  exp_reg        <= cur_word;
                  exp_addr_reg   <= addr_reg;
                  pipe_valid_reg <= 1'b1;
                  if (at_max) begin
                     state_reg <= S_DRAIN;
                  end else begin
                     addr_reg  <= addr_inc;
                     lfsr_reg  <= lfsr_adv;
                     ram_a     <= addr_inc;
                  end
               end
            end
            S_DRAIN: begin
               if (tick) begin
                  state_reg      <= S_DONE;
                  pipe_valid_reg <= 1'b0;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  pass           <= ~(err_reg | mismatch);
               end
            end
            default: begin
               state_reg <= S_IDLE;
               ram_we    <= 1'b0;
               busy      <= 1'b0;
            end
         endcase

         // Only the first mismatch is recorded as the fail address
         if (mismatch) begin
            err_reg <= 1'b1;
            if (!err_reg) begin
               fail_addr <= exp_addr_reg;
            end
`ifdef RAM_BIST_ERRCNT_EN
            err_cnt_reg <= err_cnt_reg + (AW+1)'(1);
`endif
         end
      end
   end

`ifdef RAM_BIST_ERRCNT_EN
   assign err_cnt = err_cnt_reg;
`endif

endmodule
